// File: rtl/f3m_mult_ds_if.sv
// Operand/result bundle for the GF(3^M) multiplier.
// start/a/b go in; busy/done/c come back.
interface f3m_mult_ds_if #(
  parameter int M = 97
);
  logic           start;
  logic [2*M-1:0] a;
  logic [2*M-1:0] b;
  logic           busy;
  logic           done;
  logic [2*M-1:0] c;

  modport master (
    output start, a, b,
    input  busy, done, c
  );

  modport slave (
    input  start, a, b,
    output busy, done, c
  );
endinterface

// File: rtl/f3m_mult_ds.sv
// Digit-serial GF(3^M) multiplier mod x^M + x^K + 2, D B-coeffs/cycle.
// Ports: clk, reset (async high), bus (start/a/b in, busy/done/c out).
module f3m_mult_ds #(
  parameter int M = 97,
  parameter int K = 12,
  parameter int D = 1
) (
  input  logic       clk,
  input  logic       reset,
  f3m_mult_ds_if.slave bus
);
  localparam int W  = 2 * M;
  localparam int L  = (M + D - 1) / D;
  localparam int P  = L * D;
  localparam int CW = $clog2(L + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         st, st_n;
  logic [W-1:0]   areg, a_n;
  logic [W-1:0]   acc, acc_n;
  logic [W-1:0]   creg, c_n;
  logic [2*P-1:0] breg, breg_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           done_q, done_n;
  logic [W-1:0]   v;

  function automatic logic [1:0] add3(
    input logic [1:0] x,
    input logic [1:0] y
  );
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Code 11 is not a field value; fold it to zero on entry.
  function automatic logic [W-1:0] legal(
    input logic [W-1:0] x
  );
    logic [W-1:0] r;
    r = x;
    for (int i = 0; i < M; i++)
      if (x[2*i +: 2] == 2'b11)
        r[2*i +: 2] = 2'b00;
    return r;
  endfunction

  // acc*x mod f, then + t*A. The dropped top coefficient
  // folds back as 2*top at x^K and 1*top at x^0.
  function automatic logic [W-1:0] step(
    input logic [W-1:0] acc_i,
    input logic [W-1:0] a_i,
    input logic [1:0]   t
  );
    logic [W-1:0] r;
    logic [1:0]   top;
    logic [1:0]   ai;
    logic [1:0]   ta;
    top = acc_i[W-1 -: 2];
    r   = {acc_i[W-3:0], 2'b00};
    r[2*K +: 2] = add3(r[2*K +: 2], add3(top, top));
    r[1:0]      = add3(r[1:0], top);
    for (int i = 0; i < M; i++) begin
      ai = a_i[2*i +: 2];
      ta = 2'b00;
      if (t == 2'd1)
        ta = ai;
      else if (t == 2'd2)
        ta = add3(ai, ai);
      r[2*i +: 2] = add3(r[2*i +: 2], ta);
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= IDLE;
      areg   <= '0;
      breg   <= '0;
      acc    <= '0;
      creg   <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      st     <= st_n;
      areg   <= a_n;
      breg   <= breg_n;
      acc    <= acc_n;
      creg   <= c_n;
      cnt    <= cnt_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    st_n   = st;
    a_n    = areg;
    breg_n = breg;
    acc_n  = acc;
    c_n    = creg;
    cnt_n  = cnt;
    done_n = 1'b0;
    v      = acc;
    unique case (st)
      IDLE: begin
        if (bus.start) begin
          st_n   = RUN;
          a_n    = legal(bus.a);
          // Zero left-padding up to L*D coefficients.
          breg_n = '0;
          breg_n[W-1:0] = legal(bus.b);
          acc_n  = '0;
          cnt_n  = CW'(L);
        end
      end
      RUN: begin
        for (int j = 0; j < D; j++)
          v = step(v, areg, breg[2*(P-1-j) +: 2]);
        acc_n  = v;
        breg_n = breg << (2 * D);
        if (cnt == CW'(1)) begin
          c_n    = v;
          done_n = 1'b1;
          st_n   = IDLE;
          cnt_n  = '0;
        end else begin
          cnt_n  = cnt - CW'(1);
        end
      end
    endcase
  end

  assign bus.busy = (st == RUN);
  assign bus.done = done_q;
  assign bus.c    = creg;
endmodule
